// File: rtl/modelo_planta_termica.sv
// ---------------------------------------------------------------------------
// modelo_planta_termica
//
// Closed-loop thermal plant emulator. It provides the temperature seen by the
// monitor (monitoreo_top) and reacts to the monitor's heater/fan commands.
// A registered temperature is updated once every PERIODO cycles while
// counting is enabled:
//   - heater only : rises by PASO_CAL
//   - fan only    : falls by PASO_VENT
//   - both        : unchanged, conflicto pulses for one cycle
//   - neither     : drifts one unit toward temp_ambiente (never overshoots)
// All results are clamped to [TEMP_MIN, TEMP_MAX]. A one-cycle preload strobe
// (cargar) places the temperature anywhere, also clamped.
//
// Optional build macro:
//   PLANTA_RUIDO_EN - adds +/-1 pseudo-random noise from an 8-bit Fibonacci
//                     LFSR (taps 8,6,5,4, seed 8'hA5) to every periodic
//                     update. Loads stay noise-free. Undefined by default.
//
// Ports:
//   clk            in   system clock, rising edge
//   srst           in   synchronous reset, active-high
//   habilitar      in   1 = periodic updates run
//   cargar         in   one-cycle preload strobe
//   temp_carga     in   preload value (ANCHO_TEMP bits, unsigned)
//   temp_ambiente  in   drift target (ANCHO_TEMP bits, unsigned)
//   calefactor     in   heater command
//   ventilador     in   fan command
//   temp_salida    out  plant temperature (registered)
//   muestra_valida out  one-cycle pulse after every update or load
//   saturado_alto  out  temp_salida == TEMP_MAX
//   saturado_bajo  out  temp_salida == TEMP_MIN
//   conflicto      out  one-cycle pulse: both commands high at an update
//   estado_planta  out  00 INACTIVO, 01 CONTANDO, 10 CARGA
// ---------------------------------------------------------------------------
module modelo_planta_termica #(
  parameter int ANCHO_TEMP   = 9,
  parameter int TEMP_INICIAL = 220,
  parameter int TEMP_MIN     = 100,
  parameter int TEMP_MAX     = 400,
  parameter int PASO_CAL     = 4,
  parameter int PASO_VENT    = 4,
  parameter int PERIODO      = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  habilitar,
  input  logic                  cargar,
  input  logic [ANCHO_TEMP-1:0] temp_carga,
  input  logic [ANCHO_TEMP-1:0] temp_ambiente,
  input  logic                  calefactor,
  input  logic                  ventilador,
  output logic [ANCHO_TEMP-1:0] temp_salida,
  output logic                  muestra_valida,
  output logic                  saturado_alto,
  output logic                  saturado_bajo,
  output logic                  conflicto,
  output logic [1:0]            estado_planta
);

  // Two guard bits above the temperature width: one for the sign, one of
  // headroom so that temp + step cannot wrap even when TEMP_MAX sits at the
  // top of the unsigned range.
  localparam int AW = ANCHO_TEMP + 2;
  localparam int CW = $clog2(PERIODO);

  localparam logic signed [AW-1:0] MIN_S  = AW'(TEMP_MIN);
  localparam logic signed [AW-1:0] MAX_S  = AW'(TEMP_MAX);
  localparam logic signed [AW-1:0] CAL_S  = AW'(PASO_CAL);
  localparam logic signed [AW-1:0] VENT_S = AW'(PASO_VENT);
  localparam logic signed [AW-1:0] UNO_S  = AW'(1);

  localparam logic [CW-1:0]         CNT_ULT = CW'(PERIODO - 1);
  localparam logic [ANCHO_TEMP-1:0] T_INI   = ANCHO_TEMP'(TEMP_INICIAL);
  localparam logic [ANCHO_TEMP-1:0] T_MIN   = ANCHO_TEMP'(TEMP_MIN);
  localparam logic [ANCHO_TEMP-1:0] T_MAX   = ANCHO_TEMP'(TEMP_MAX);

  typedef enum logic [1:0] {
    INACTIVO = 2'b00,
    CONTANDO = 2'b01,
    CARGA    = 2'b10
  } estado_t;

  // Zero-extend an unsigned temperature into the signed working width.
  function automatic logic signed [AW-1:0] extender(input logic [ANCHO_TEMP-1:0] v);
    return $signed({2'b00, v});
  endfunction

  // Clamp a signed working value into [TEMP_MIN, TEMP_MAX].
  function automatic logic [ANCHO_TEMP-1:0] saturar(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] r;
    if (v < MIN_S) begin
      r = MIN_S;
    end else if (v > MAX_S) begin
      r = MAX_S;
    end else begin
      r = v;
    end
    return ANCHO_TEMP'(r);
  endfunction

  // One unit toward the target; equal values leave the temperature alone,
  // so the result can never cross the target.
  function automatic logic signed [AW-1:0] deriva(input logic signed [AW-1:0] t,
                                                  input logic signed [AW-1:0] a);
    logic signed [AW-1:0] r;
    if (a > t) begin
      r = t + UNO_S;
    end else if (a < t) begin
      r = t - UNO_S;
    end else begin
      r = t;
    end
    return r;
  endfunction

  estado_t               estado, estado_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [ANCHO_TEMP-1:0] temp_nxt;
  logic                  mv_nxt;
  logic                  conf_nxt;
  logic                  actualizar;
  logic signed [AW-1:0]  temp_s;
  logic signed [AW-1:0]  paso_s;
  logic signed [AW-1:0]  paso_final;

  assign temp_s = extender(temp_salida);

  // A periodic update is due on this edge; a load on the same edge wins.
  assign actualizar = !cargar && (estado == CONTANDO) && habilitar && (cnt == CNT_ULT);

  // Step / drift term, before noise and clamping.
  always_comb begin
    paso_s = temp_s;
    case ({calefactor, ventilador})
      2'b10:   paso_s = temp_s + CAL_S;
      2'b01:   paso_s = temp_s - VENT_S;
      2'b11:   paso_s = temp_s;
      default: paso_s = deriva(temp_s, extender(temp_ambiente));
    endcase
  end

`ifdef PLANTA_RUIDO_EN
  logic [7:0]           lfsr;
  logic signed [AW-1:0] ruido_s;

  // Fibonacci LFSR x^8 + x^6 + x^5 + x^4 + 1, stepped once per update.
  always_ff @(posedge clk) begin
    if (srst) begin
      lfsr <= 8'hA5;
    end else if (actualizar) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  always_comb begin
    ruido_s = '0;
    case (lfsr[1:0])
      2'b01:   ruido_s = UNO_S;
      2'b10:   ruido_s = -UNO_S;
      default: ruido_s = '0;
    endcase
  end

  assign paso_final = paso_s + ruido_s;
`else
  assign paso_final = paso_s;
`endif

  // Next-state / next-output logic. Priority below srst: cargar, then the
  // periodic update.
  always_comb begin
    estado_nxt = estado;
    cnt_nxt    = cnt;
    temp_nxt   = temp_salida;
    mv_nxt     = 1'b0;
    conf_nxt   = 1'b0;
    if (cargar) begin
      estado_nxt = CARGA;
      cnt_nxt    = '0;
      temp_nxt   = saturar(extender(temp_carga));
      mv_nxt     = 1'b1;
    end else begin
      case (estado)
        INACTIVO: begin
          cnt_nxt = '0;
          if (habilitar) begin
            estado_nxt = CONTANDO;
          end
        end
        CONTANDO: begin
          if (!habilitar) begin
            estado_nxt = INACTIVO;
            cnt_nxt    = '0;
          end else if (actualizar) begin
            cnt_nxt  = '0;
            temp_nxt = saturar(paso_final);
            mv_nxt   = 1'b1;
            conf_nxt = calefactor & ventilador;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        CARGA: begin
          cnt_nxt    = '0;
          estado_nxt = habilitar ? CONTANDO : INACTIVO;
        end
        default: begin
          cnt_nxt    = '0;
          estado_nxt = INACTIVO;
        end
      endcase
    end
  end

  // ---- register stage: plant state ----
  always_ff @(posedge clk) begin
    if (srst) begin
      estado         <= INACTIVO;
      cnt            <= '0;
      temp_salida    <= T_INI;
      muestra_valida <= 1'b0;
      conflicto      <= 1'b0;
    end else begin
      estado         <= estado_nxt;
      cnt            <= cnt_nxt;
      temp_salida    <= temp_nxt;
      muestra_valida <= mv_nxt;
      conflicto      <= conf_nxt;
    end
  end

  assign estado_planta = estado;
  assign saturado_alto = (temp_salida == T_MAX);
  assign saturado_bajo = (temp_salida == T_MIN);

endmodule
